// File: rtl/control_sequencer_if.sv
// control_sequencer_if
// Groups the handshake, decode and trap signals between the control
// sequencer and the surrounding datapath (fetch, register file, ALU,
// PC logic, data memory).
//
// Signals:
//   INSTRUCTION   fetch -> seq   instruction word
//   INSTR_VALID   fetch -> seq   fetch presents a new instruction
//   BUSYWAIT      mem   -> seq   data memory busy
//   INSTR_READY   seq   -> fetch accept / PC-advance enable
//   MUX1/2/4      seq   -> dp    negate, reg/imm, mem/ALU write-back selects
//   ALUOP         seq   -> ALU   ALU operation
//   WRITEENABLE   seq   -> RF    register-file write strobe
//   JUMP/BRANCH   seq   -> PC    PC control flags
//   READ/WRITE    seq   -> mem   data-memory requests
//   ILLEGAL       seq   -> sys   sticky illegal-opcode trap
//   MEM_ERR       seq   -> sys   sticky memory-timeout trap
//   STATE         seq   -> dbg   IDLE=0, EXEC=1, MEMWAIT=2, TRAP=3
//
// Modports: master = sequencer side, slave = datapath side.
interface control_sequencer_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int ALUOP_WIDTH = 3
) ();

  logic [INSTR_WIDTH-1:0] INSTRUCTION;
  logic                   INSTR_VALID;
  logic                   BUSYWAIT;
  logic                   INSTR_READY;
  logic                   MUX1;
  logic                   MUX2;
  logic                   MUX4;
  logic [ALUOP_WIDTH-1:0] ALUOP;
  logic                   WRITEENABLE;
  logic                   JUMP;
  logic                   BRANCH;
  logic                   READ;
  logic                   WRITE;
  logic                   ILLEGAL;
  logic                   MEM_ERR;
  logic [1:0]             STATE;

  modport master (
    input  INSTRUCTION, INSTR_VALID, BUSYWAIT,
    output INSTR_READY, MUX1, MUX2, MUX4, ALUOP, WRITEENABLE,
           JUMP, BRANCH, READ, WRITE, ILLEGAL, MEM_ERR, STATE
  );

  modport slave (
    output INSTRUCTION, INSTR_VALID, BUSYWAIT,
    input  INSTR_READY, MUX1, MUX2, MUX4, ALUOP, WRITEENABLE,
           JUMP, BRANCH, READ, WRITE, ILLEGAL, MEM_ERR, STATE
  );

endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
// Registered, stall-aware instruction control sequencer. Decodes the opcode
// into mux selects, ALU operation and PC flags, holds data-memory requests
// until the memory drops BUSYWAIT, sequences load write-back, and traps on
// illegal opcodes or a memory timeout.
//
// Ports:
//   CLK    rising-edge clock
//   RESET  asynchronous active-low reset
//   bus    control_sequencer_if.master (instruction handshake, decode
//          outputs, memory requests, trap flags, debug state)
module control_sequencer #(
  parameter int INSTR_WIDTH  = 32,
  parameter int OPCODE_WIDTH = 8,
  parameter int ALUOP_WIDTH  = 3,
  parameter int NUM_OPCODES  = 17,
  parameter int MEM_TIMEOUT  = 255
) (
  input logic                CLK,
  input logic                RESET,
  control_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    MEMWAIT = 2'd2,
    TRAP    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   mux1_q, mux1_d;
  logic                   mux2_q, mux2_d;
  logic                   mux4_q, mux4_d;
  logic [ALUOP_WIDTH-1:0] aluOp_q, aluOp_d;
  logic                   writeEnable_q, writeEnable_d;
  logic                   jump_q, jump_d;
  logic                   branch_q, branch_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic                   illegal_q, illegal_d;
  logic                   memErr_q, memErr_d;
  logic [CNT_W-1:0]       memCount_q, memCount_d;

  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    decLegal;
  logic                    decM1;
  logic                    decM2;
  logic                    decM4;
  logic [ALUOP_WIDTH-1:0]  decAlu;
  logic                    decWe;
  logic                    decJump;
  logic                    decBranch;
  logic                    decRead;
  logic                    decWrite;

  // Only the opcode field drives the control path; the remaining
  // instruction bits belong to the datapath (register numbers, immediates).
  logic unusedOperandBits;
  assign unusedOperandBits = ^bus.INSTRUCTION[INSTR_WIDTH-OPCODE_WIDTH-1:0];

  assign opcode = bus.INSTRUCTION[INSTR_WIDTH-1 -: OPCODE_WIDTH];

  // Pure opcode decode. Every field defaults to 0 so each case item only
  // lists what it turns on. Anything outside the known table, or at or above
  // NUM_OPCODES, is flagged illegal.
  always_comb begin
    decLegal  = 1'b1;
    decM1     = 1'b0;
    decM2     = 1'b0;
    decM4     = 1'b0;
    decAlu    = '0;
    decWe     = 1'b0;
    decJump   = 1'b0;
    decBranch = 1'b0;
    decRead   = 1'b0;
    decWrite  = 1'b0;
    case (opcode)
      OPCODE_WIDTH'(0):  begin decWe = 1'b1; end
      OPCODE_WIDTH'(1):  begin decM2 = 1'b1; decWe = 1'b1; end
      OPCODE_WIDTH'(2):  begin decM2 = 1'b1; decAlu = ALUOP_WIDTH'(1); decWe = 1'b1; end
      OPCODE_WIDTH'(3):  begin decM1 = 1'b1; decM2 = 1'b1; decAlu = ALUOP_WIDTH'(1); decWe = 1'b1; end
      OPCODE_WIDTH'(4):  begin decM2 = 1'b1; decAlu = ALUOP_WIDTH'(2); decWe = 1'b1; end
      OPCODE_WIDTH'(5):  begin decM2 = 1'b1; decAlu = ALUOP_WIDTH'(3); decWe = 1'b1; end
      OPCODE_WIDTH'(6):  begin decJump = 1'b1; end
      OPCODE_WIDTH'(7):  begin decM1 = 1'b1; decM2 = 1'b1; decAlu = ALUOP_WIDTH'(1); decBranch = 1'b1; end
      OPCODE_WIDTH'(8):  begin decM2 = 1'b1; decAlu = ALUOP_WIDTH'(4); decWe = 1'b1; end
      OPCODE_WIDTH'(9):  begin decAlu = ALUOP_WIDTH'(5); decWe = 1'b1; end
      OPCODE_WIDTH'(10): begin decAlu = ALUOP_WIDTH'(6); decWe = 1'b1; end
      OPCODE_WIDTH'(11): begin decAlu = ALUOP_WIDTH'(7); decWe = 1'b1; end
      OPCODE_WIDTH'(12): begin
        decM1 = 1'b1; decM2 = 1'b1; decAlu = ALUOP_WIDTH'(1);
        decJump = 1'b1; decBranch = 1'b1;
      end
      OPCODE_WIDTH'(13): begin decM2 = 1'b1; decRead = 1'b1; decM4 = 1'b1; end
      OPCODE_WIDTH'(14): begin decRead = 1'b1; decM4 = 1'b1; end
      OPCODE_WIDTH'(15): begin decM2 = 1'b1; decWrite = 1'b1; end
      OPCODE_WIDTH'(16): begin decWrite = 1'b1; end
      default:           begin decLegal = 1'b0; end
    endcase
    if (int'(opcode) >= NUM_OPCODES) begin
      decLegal = 1'b0;
    end
  end

  // Next-state and next-output logic. Every register holds by default;
  // each state then clears the strobes it must not carry forward. Mux
  // selects and ALUOP are left holding outside an accept so the datapath
  // never sees a spurious change between instructions.
  always_comb begin
    state_d       = state_q;
    ready_d       = ready_q;
    mux1_d        = mux1_q;
    mux2_d        = mux2_q;
    mux4_d        = mux4_q;
    aluOp_d       = aluOp_q;
    writeEnable_d = writeEnable_q;
    jump_d        = jump_q;
    branch_d      = branch_q;
    read_d        = read_q;
    write_d       = write_q;
    illegal_d     = illegal_q;
    memErr_d      = memErr_q;
    memCount_d    = memCount_q;

    case (state_q)
      IDLE: begin
        ready_d       = 1'b1;
        writeEnable_d = 1'b0;
        jump_d        = 1'b0;
        branch_d      = 1'b0;
        read_d        = 1'b0;
        write_d       = 1'b0;
        if (bus.INSTR_VALID) begin
          ready_d = 1'b0;
          if (!decLegal) begin
            state_d   = TRAP;
            illegal_d = 1'b1;
          end else if (decRead || decWrite) begin
            state_d    = MEMWAIT;
            mux1_d     = decM1;
            mux2_d     = decM2;
            mux4_d     = decM4;
            aluOp_d    = decAlu;
            read_d     = decRead;
            write_d    = decWrite;
            memCount_d = '0;
          end else begin
            state_d       = EXEC;
            mux1_d        = decM1;
            mux2_d        = decM2;
            mux4_d        = decM4;
            aluOp_d       = decAlu;
            writeEnable_d = decWe;
            jump_d        = decJump;
            branch_d      = decBranch;
          end
        end
      end

      EXEC: begin
        state_d       = IDLE;
        ready_d       = 1'b1;
        writeEnable_d = 1'b0;
        jump_d        = 1'b0;
        branch_d      = 1'b0;
      end

      // A count of zero marks the first MEMWAIT cycle, where BUSYWAIT is
      // ignored so the memory always sees at least two request cycles.
      // read_q distinguishes a load from a store on exit. The count never
      // passes MEM_TIMEOUT because the trap fires as it gets there.
      MEMWAIT: begin
        ready_d       = 1'b0;
        writeEnable_d = 1'b0;
        memCount_d    = memCount_q + CNT_W'(1);
        if (memCount_q != '0) begin
          if (!bus.BUSYWAIT) begin
            if (read_q) begin
              state_d       = EXEC;
              read_d        = 1'b0;
              mux4_d        = 1'b1;
              writeEnable_d = 1'b1;
            end else begin
              state_d = IDLE;
              write_d = 1'b0;
              ready_d = 1'b1;
            end
          end else if (int'(memCount_q) + 1 >= MEM_TIMEOUT) begin
            state_d  = TRAP;
            memErr_d = 1'b1;
            read_d   = 1'b0;
            write_d  = 1'b0;
          end
        end
      end

      TRAP: begin
        ready_d       = 1'b0;
        writeEnable_d = 1'b0;
        jump_d        = 1'b0;
        branch_d      = 1'b0;
        read_d        = 1'b0;
        write_d       = 1'b0;
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous so an in-flight
  // memory request drops the moment RESET goes low.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= IDLE;
      ready_q       <= 1'b1;
      mux1_q        <= 1'b0;
      mux2_q        <= 1'b0;
      mux4_q        <= 1'b0;
      aluOp_q       <= '0;
      writeEnable_q <= 1'b0;
      jump_q        <= 1'b0;
      branch_q      <= 1'b0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      illegal_q     <= 1'b0;
      memErr_q      <= 1'b0;
      memCount_q    <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      mux1_q        <= mux1_d;
      mux2_q        <= mux2_d;
      mux4_q        <= mux4_d;
      aluOp_q       <= aluOp_d;
      writeEnable_q <= writeEnable_d;
      jump_q        <= jump_d;
      branch_q      <= branch_d;
      read_q        <= read_d;
      write_q       <= write_d;
      illegal_q     <= illegal_d;
      memErr_q      <= memErr_d;
      memCount_q    <= memCount_d;
    end
  end

  assign bus.INSTR_READY = ready_q;
  assign bus.MUX1        = mux1_q;
  assign bus.MUX2        = mux2_q;
  assign bus.MUX4        = mux4_q;
  assign bus.ALUOP       = aluOp_q;
  assign bus.WRITEENABLE = writeEnable_q;
  assign bus.JUMP        = jump_q;
  assign bus.BRANCH      = branch_q;
  assign bus.READ        = read_q;
  assign bus.WRITE       = write_q;
  assign bus.ILLEGAL     = illegal_q;
  assign bus.MEM_ERR     = memErr_q;
  assign bus.STATE       = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
// Directed testbench for control_sequencer with hand-computed expectations.
// The sequencer is built with MEM_TIMEOUT=4 so the timeout trap is reachable.
module tb_control_sequencer;

  logic CLK = 1'b0;
  logic RESET;
  int   compareCount  = 0;
  int   mismatchCount = 0;

  control_sequencer_if #(.INSTR_WIDTH(32), .ALUOP_WIDTH(3)) bus ();

  control_sequencer #(
    .INSTR_WIDTH (32),
    .OPCODE_WIDTH(8),
    .ALUOP_WIDTH (3),
    .NUM_OPCODES (17),
    .MEM_TIMEOUT (4)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  // 10 time-unit clock period.
  always #5 CLK = ~CLK;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive the fetch/memory side; operand bits carry a fixed junk pattern.
  task automatic applyStimulus(input logic valid, input logic [7:0] op, input logic busy);
    bus.INSTR_VALID = valid;
    bus.INSTRUCTION = {op, 24'hA5C35A};
    bus.BUSYWAIT    = busy;
  endtask

  // Advance one clock edge and settle 1 unit past it.
  task automatic stepCycle();
    @(posedge CLK);
    #1;
  endtask

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // {MUX1, MUX2, ALUOP[2:0], WRITEENABLE, JUMP, BRANCH}
  function automatic logic [7:0] ctrlBits();
    return {bus.MUX1, bus.MUX2, bus.ALUOP, bus.WRITEENABLE, bus.JUMP, bus.BRANCH};
  endfunction

  // {WRITEENABLE, JUMP, BRANCH, READ, WRITE}
  function automatic logic [4:0] strobeBits();
    return {bus.WRITEENABLE, bus.JUMP, bus.BRANCH, bus.READ, bus.WRITE};
  endfunction

  logic [7:0] decOps [13] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6,
                              8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
  logic [7:0] decExp [13] = '{8'h04, 8'h44, 8'h4C, 8'hCC, 8'h54, 8'h5C, 8'h02,
                              8'hC9, 8'h64, 8'h2C, 8'h34, 8'h3C, 8'hCB};

  initial begin
    int   cycles;
    logic weSeen;

    // Reset state
    RESET = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    #12;
    checkOutput("reset STATE", bus.STATE, 0);
    checkOutput("reset READY", bus.INSTR_READY, 1);
    checkOutput("reset ctrl", ctrlBits(), 0);
    checkOutput("reset strobes", strobeBits(), 0);
    checkOutput("reset flags", {bus.ILLEGAL, bus.MEM_ERR, bus.MUX4}, 0);
    RESET = 1'b1;

    // add: one-cycle control pulse, ready back on the next edge
    applyStimulus(1'b1, 8'h02, 1'b0);
    stepCycle();
    checkOutput("add ctrl", ctrlBits(), 8'h4C);
    checkOutput("add READY", bus.INSTR_READY, 0);
    checkOutput("add STATE", bus.STATE, 1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    stepCycle();
    checkOutput("add WE off", bus.WRITEENABLE, 0);
    checkOutput("add READY back", bus.INSTR_READY, 1);
    checkOutput("add STATE idle", bus.STATE, 0);

    // Decode table over all non-memory opcodes
    foreach (decOps[i]) begin
      applyStimulus(1'b1, decOps[i], 1'b0);
      stepCycle();
      checkOutput($sformatf("decode op%0d", decOps[i]), ctrlBits(), decExp[i]);
      applyStimulus(1'b0, 8'h00, 1'b0);
      stepCycle();
      checkOutput($sformatf("decode op%0d release", decOps[i]),
                  {bus.INSTR_READY, bus.WRITEENABLE, bus.JUMP, bus.BRANCH}, 4'b1000);
    end

    // swi with BUSYWAIT low: WRITE exactly two cycles, no WE
    applyStimulus(1'b1, 8'h10, 1'b0);
    stepCycle();
    checkOutput("swi first", {bus.STATE, bus.WRITE, bus.MUX2, bus.INSTR_READY}, 5'b10100);
    applyStimulus(1'b0, 8'h00, 1'b0);
    cycles = 1;
    weSeen = bus.WRITEENABLE;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      weSeen |= bus.WRITEENABLE;
      if (!bus.WRITE) break;
      cycles++;
    end
    checkOutput("swi WRITE cycles", cycles, 2);
    checkOutput("swi WE never", weSeen, 0);
    checkOutput("swi back idle", {bus.STATE, bus.INSTR_READY}, 3'b001);

    // lwd with BUSYWAIT high for 3 cycles: READ 4 cycles, then WE 1 cycle
    applyStimulus(1'b1, 8'h0D, 1'b1);
    stepCycle();
    checkOutput("lwd first", {bus.STATE, bus.READ, bus.MUX4, bus.MUX2, bus.WRITEENABLE}, 6'b101110);
    applyStimulus(1'b0, 8'h00, 1'b1);
    cycles = 1;
    weSeen = 1'b0;
    for (int i = 1; i < 12; i++) begin
      stepCycle();
      if (!bus.READ) break;
      weSeen |= bus.WRITEENABLE;
      cycles++;
      if (i == 3) bus.BUSYWAIT = 1'b0;
    end
    checkOutput("lwd READ cycles", cycles, 4);
    checkOutput("lwd WE during wait", weSeen, 0);
    checkOutput("lwd writeback", {bus.STATE, bus.WRITEENABLE, bus.MUX4, bus.READ}, 5'b01110);
    stepCycle();
    checkOutput("lwd WE one cycle", {bus.STATE, bus.WRITEENABLE, bus.INSTR_READY}, 4'b0001);

    // lwi interrupted by reset: READ drops at once, no WE afterwards
    applyStimulus(1'b1, 8'h0E, 1'b1);
    stepCycle();
    checkOutput("lwi first", {bus.STATE, bus.READ, bus.MUX4, bus.MUX2}, 5'b10110);
    applyStimulus(1'b0, 8'h00, 1'b1);
    stepCycle();
    checkOutput("lwi still waiting", bus.READ, 1);
    #2;
    RESET = 1'b0;
    #1;
    checkOutput("lwi async reset", {bus.STATE, bus.READ, bus.INSTR_READY}, 4'b0001);
    #1;
    RESET = 1'b1;
    bus.BUSYWAIT = 1'b0;
    weSeen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      weSeen |= bus.WRITEENABLE;
    end
    checkOutput("lwi no WE after reset", weSeen, 0);

    // swd with BUSYWAIT stuck: timeout trap after 4 WRITE cycles
    applyStimulus(1'b1, 8'h0F, 1'b1);
    stepCycle();
    checkOutput("swd first", {bus.STATE, bus.WRITE}, 3'b101);
    applyStimulus(1'b0, 8'h00, 1'b1);
    cycles = 1;
    for (int i = 0; i < 12; i++) begin
      stepCycle();
      if (!bus.WRITE) break;
      cycles++;
    end
    checkOutput("swd WRITE cycles", cycles, 4);
    checkOutput("swd trap", {bus.STATE, bus.MEM_ERR, bus.INSTR_READY, bus.ILLEGAL}, 5'b11100);
    applyStimulus(1'b1, 8'h02, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("trap ignores valid", {bus.STATE, bus.WRITEENABLE, bus.INSTR_READY, bus.MEM_ERR}, 5'b11001);
    RESET = 1'b0;
    #1;
    checkOutput("reset clears MEM_ERR", {bus.MEM_ERR, bus.STATE, bus.INSTR_READY}, 4'b0001);
    RESET = 1'b1;

    // Illegal opcode 0x11
    applyStimulus(1'b1, 8'h11, 1'b0);
    stepCycle();
    checkOutput("illegal trap", {bus.STATE, bus.ILLEGAL, bus.INSTR_READY}, 4'b1110);
    checkOutput("illegal strobes", strobeBits(), 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    stepCycle();
    checkOutput("illegal sticky", {bus.STATE, bus.ILLEGAL}, 3'b111);
    RESET = 1'b0;
    #1;
    checkOutput("reset clears ILLEGAL", {bus.ILLEGAL, bus.INSTR_READY, bus.STATE}, 4'b0100);
    RESET = 1'b1;
    stepCycle();
    checkOutput("ready after reset", bus.INSTR_READY, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Registered, stall-aware instruction control sequencer for the processor datapath. It sits between instruction fetch and the register file, ALU, PC logic and data memory. It decodes the opcode into mux selects, ALU operation and branch/jump flags. It holds data-memory READ/WRITE until the memory drops BUSYWAIT, sequences load write-back, and traps on illegal opcodes or memory timeout.

## Interface
- INSTR_WIDTH, 32, instruction word width; opcode is INSTRUCTION[INSTR_WIDTH-1 -: OPCODE_WIDTH]
- OPCODE_WIDTH, 8, opcode field width
- ALUOP_WIDTH, 3, ALUOP output width (>=3)
- NUM_OPCODES, 17, opcodes >= NUM_OPCODES are illegal (legal range 0..16)
- MEM_TIMEOUT, 255, max cycles in MEMWAIT before trap; counter width $clog2(MEM_TIMEOUT+1)

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- INSTRUCTION  in  INSTR_WIDTH  instruction word, sampled when INSTR_VALID && INSTR_READY
- INSTR_VALID  in  1  fetch presents a new instruction
- BUSYWAIT  in  1  data memory busy
- INSTR_READY  out  1  sequencer accepts an instruction this cycle; doubles as PC-advance enable
- MUX1, MUX2, MUX4  out  1  negate-select, register/immediate select, memory/ALU write-back select
- ALUOP  out  ALUOP_WIDTH  ALU operation
- WRITEENABLE  out  1  register-file write strobe
- JUMP, BRANCH  out  1  PC control flags
- READ, WRITE  out  1  data-memory requests
- ILLEGAL  out  1  sticky illegal-opcode trap flag
- MEM_ERR  out  1  sticky memory-timeout trap flag
- STATE  out  2  debug: IDLE=0, EXEC=1, MEMWAIT=2, TRAP=3

## Operation
- All outputs registered. Async reset (RESET=0) forces STATE=IDLE, all outputs 0 except INSTR_READY=1, and clears the timeout counter.
- Decode (fields not listed are 0):
  - 0 loadi: M2=0, ALU 0, WE.
  - 1 mov: M2=1, ALU 0, WE.
  - 2 add: M2=1, ALU 1, WE.
  - 3 sub: M1=1, M2=1, ALU 1, WE.
  - 4 and: M2=1, ALU 2, WE.
  - 5 or: M2=1, ALU 3, WE.
  - 6 j: JUMP.
  - 7 beq: M1=1, M2=1, ALU 1, BRANCH.
  - 8 mult: M2=1, ALU 4, WE.
  - 9 sll/srl: M2=0, ALU 5, WE.
  - 10 sra: M2=0, ALU 6, WE.
  - 11 ror: M2=0, ALU 7, WE.
  - 12 bne: M1=1, M2=1, ALU 1, JUMP+BRANCH.
  - 13 lwd: M2=1, READ, M4=1.
  - 14 lwi: M2=0, READ, M4=1.
  - 15 swd: M2=1, WRITE.
  - 16 swi: M2=0, WRITE.
- Branches, jumps and stores never assert WRITEENABLE.
- FSM:
  - IDLE: INSTR_READY=1. On accept: non-memory legal opcode -> EXEC; load/store -> MEMWAIT with READ/WRITE set; illegal -> TRAP with ILLEGAL=1.
  - EXEC: controls (incl. WRITEENABLE) valid for exactly one cycle; INSTR_READY=0; -> IDLE, clearing WRITEENABLE/JUMP/BRANCH.
  - MEMWAIT: READ/WRITE, mux selects and ALUOP held; INSTR_READY=0; WRITEENABLE=0. Counter increments each cycle. BUSYWAIT is ignored on the first MEMWAIT cycle. After that, the first edge with BUSYWAIT=0 exits: load -> EXEC with READ=0, M4=1, WRITEENABLE=1; store -> IDLE with WRITE=0. If the counter reaches MEM_TIMEOUT while BUSYWAIT=1 -> TRAP, MEM_ERR=1, READ/WRITE=0.
  - TRAP: all strobes 0, INSTR_READY=0, flags held; exit only by reset.
- INSTR_VALID is ignored outside IDLE.

## Timing
- Non-memory instruction: accept at edge N; controls valid N..N+1; INSTR_READY high again from edge N+1. Throughput is 1 instruction per 2 cycles.
- Load with BUSYWAIT high for k>=1 cycles after the request: READ high for k+1 cycles, then WRITEENABLE for 1 cycle. Store: WRITE high for k+1 cycles.
- BUSYWAIT low in the first MEMWAIT cycle still costs 2 MEMWAIT cycles (minimum latency).
- Reset mid-MEMWAIT drops READ/WRITE asynchronously and never produces WRITEENABLE.

## Test plan
- Reset released, INSTR_VALID=1, add (0x02xxxxxx) -> next cycle WRITEENABLE=1, ALUOP=1, M2=1; following cycle WRITEENABLE=0, INSTR_READY=1.
- beq, then j, then swi with BUSYWAIT=0 -> WRITEENABLE never 1; BRANCH=1 / JUMP=1 each for one cycle; WRITE high exactly 2 cycles.
- lwd with BUSYWAIT=1 for 3 cycles -> READ high 4 cycles, M4=1, then WRITEENABLE=1 for 1 cycle, READ=0.
- swd with BUSYWAIT stuck 1, MEM_TIMEOUT=4 -> WRITE drops, STATE=3, MEM_ERR=1; further INSTR_VALID is ignored.
- Opcode 0x11 -> ILLEGAL=1, STATE=3, no strobes asserted; reset clears ILLEGAL and INSTR_READY returns to 1.
- RESET low during MEMWAIT of lwi -> READ=0 immediately (asynchronously), STATE=0, no WRITEENABLE pulse after release.
